// File: rtl/spi_pkg.sv
// Shared definitions for the SPI full-duplex master:
// FSM state encoding and the default sclk divider.
package spi_pkg;

    localparam int unsigned SPI_CLK_DIV = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/spi_clk_gen.sv
// sclk generator: toggles sclk every CLK_DIV clk cycles while enabled,
// with one-clk strobes on the edges where sclk rises or falls.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] div_q, div_d;
    logic       sclk_q, sclk_d;
    logic       tick;

    assign tick   = en_i && (div_q == 8'(CLK_DIV - 1));
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = 8'd0;
            sclk_d = 1'b0;
        end else if (tick) begin
            div_d  = 8'd0;
            sclk_d = ~sclk_q;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_full_duplex.sv
// SPI master, mode 1 (CPOL=0, CPHA=1), one byte per transfer,
// full duplex: shifts data out on sclk rise and miso in on sclk fall.
module spi_full_duplex
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       tx_en,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       cs,
    output logic [7:0] dout,
    output logic       done_rx
);

    logic [1:0] state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic [2:0] bit_q, bit_d;
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic       done_q, done_d;
    logic       gen_en, sclk_rise, sclk_fall;

    assign gen_en = (state_q == ST_XFER);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (gen_en),
        .sclk_o(sclk),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                bit_d  = 3'd0;
                if (tx_en) begin
                    state_d = ST_XFER;
                    tx_d    = data;
                    rx_d    = 8'h00;
                    cs_d    = 1'b0;
                end
            end
            (state_q == ST_XFER): begin
                if (sclk_rise) begin
                    mosi_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                // The 8th falling edge closes the byte.
                if (sclk_fall) begin
                    rx_d  = {rx_q[6:0], miso};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_DONE;
                    end
                end
            end
            (state_q == ST_DONE): begin
                dout_d  = rx_q;
                done_d  = 1'b1;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            dout_q  <= 8'h00;
            bit_q   <= 3'd0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign mosi    = mosi_q;
    assign cs      = cs_q;
    assign dout    = dout_q;
    assign done_rx = done_q;

endmodule

// File: tb/tb_spi_full_duplex.sv
// Randomized bench for spi_full_duplex against a cycle-position model
// of the transfer, plus a mode-1 slave that shifts out on sclk rise.
module tb_spi_full_duplex;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       tx_en;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic       cs;
    logic [7:0] dout;
    logic       done_rx;

    logic [7:0] slave_next;
    logic [7:0] slave_sr;

    int checks = 0;
    int errors = 0;

    // Model state: position within the current transfer.
    bit         m_busy = 1'b0;
    int         m_t    = 0;
    int         r;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_rx   = 8'h00;
    logic [7:0] m_dout = 8'h00;
    logic       e_cs   = 1'b1;
    logic       e_sclk = 1'b0;
    logic       e_mosi = 1'b0;
    logic       e_done = 1'b0;

    spi_full_duplex #(
        .CLK_DIV(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .tx_en  (tx_en),
        .miso   (miso),
        .mosi   (mosi),
        .sclk   (sclk),
        .cs     (cs),
        .dout   (dout),
        .done_rx(done_rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: loads its byte when cs falls, presents MSB first on sclk rise.
    initial begin
        miso     = 1'b0;
        slave_sr = 8'h00;
        forever begin
            @(posedge sclk or negedge cs);
            if (sclk) begin
                miso     = slave_sr[7];
                slave_sr = {slave_sr[6:0], 1'b0};
            end else begin
                slave_sr = slave_next;
            end
        end
    end

    // Reference model: outputs follow from the edge count t since cs fell.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_busy = 1'b0;
                m_t    = 0;
                m_rx   = 8'h00;
                m_dout = 8'h00;
                e_cs   = 1'b1;
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                e_done = 1'b0;
            end else if (m_busy) begin
                m_t++;
                e_done = 1'b0;
                if ((m_t % (2 * D)) == 0 && m_t <= 16 * D)
                    m_rx = {m_rx[6:0], miso};
                if (m_t == 16 * D + 1) begin
                    m_busy = 1'b0;
                    m_dout = m_rx;
                    e_done = 1'b1;
                    e_cs   = 1'b1;
                    e_sclk = 1'b0;
                    e_mosi = 1'b0;
                end else begin
                    e_cs   = 1'b0;
                    e_sclk = (m_t < 16 * D) && (((m_t / D) % 2) == 1);
                    r = (m_t / D + 1) / 2;
                    if (r > 8) r = 8;
                    e_mosi = (r == 0) ? 1'b0 : m_byte[3'(8 - r)];
                end
            end else begin
                e_done = 1'b0;
                e_cs   = 1'b1;
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                if (tx_en) begin
                    m_busy = 1'b1;
                    m_t    = 0;
                    m_byte = data;
                    m_rx   = 8'h00;
                    e_cs   = 1'b0;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("outputs", 32'({cs, sclk, mosi, done_rx, dout}),
                32'({e_cs, e_sclk, e_mosi, e_done, m_dout}));
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl,
                        input bit wiggle);
        int         lat;
        int         pulses;
        logic [7:0] mb;
        logic       ps;
        bit         seen;
        slave_next = sl;
        data       = tx;
        tx_en      = 1'b1;
        @(negedge clk);
        chk("cs_fall", 32'(cs), 32'(1'b0));
        tx_en  = 1'b0;
        lat    = 0;
        pulses = 0;
        mb     = 8'h00;
        ps     = sclk;
        seen   = 1'b0;
        for (int i = 0; i < 40 * D; i++) begin
            @(negedge clk);
            lat++;
            if (wiggle) begin
                data  = 8'($urandom);
                tx_en = 1'($urandom);
            end
            if (!ps && sclk) pulses++;
            if (ps && !sclk) mb = {mb[6:0], mosi};
            ps = sclk;
            if (done_rx) begin
                seen = 1'b1;
                break;
            end
        end
        tx_en = 1'b0;
        chk("done_seen", 32'(seen), 32'(1'b1));
        chk("latency", lat, 16 * D + 1);
        chk("sclk_pulses", pulses, 8);
        chk("mosi_bits", 32'(mb), 32'(tx));
        chk("dout", 32'(dout), 32'(sl));
        chk("cs_at_done", 32'(cs), 32'(1'b1));
        @(negedge clk);
        chk("done_width", 32'(done_rx), 32'(1'b0));
    endtask

    initial begin
        int         falls;
        int         dones;
        logic       ps;
        logic [7:0] s1;
        logic [7:0] s2;

        rst        = 1'b0;
        tx_en      = 1'b1;
        data       = 8'($urandom);
        slave_next = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("reset_idle", 32'({cs, sclk, mosi, done_rx, dout}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        end
        tx_en = 1'b0;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("wait_idle", 32'(cs), 32'(1'b1));
        end

        // Abort after the third sclk pulse.
        slave_next = 8'($urandom);
        data       = 8'($urandom);
        tx_en      = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        falls = 0;
        ps    = sclk;
        for (int i = 0; i < 40 * D && falls < 3; i++) begin
            @(negedge clk);
            if (ps && !sclk) falls++;
            ps = sclk;
        end
        chk("abort_falls", falls, 3);
        #2 rst = 1'b0;
        #1 chk("abort_idle", 32'({cs, sclk, mosi, done_rx, dout}),
               32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        xfer(8'hAA, 8'h55, 1'b0);
        chk("basic_dout", 32'(dout), 32'(8'h55));
        repeat (2) @(negedge clk);
        xfer(8'h96, 8'h69, 1'b1);

        // Back-to-back with tx_en held high.
        s1         = 8'($urandom);
        s2         = 8'($urandom);
        slave_next = s1;
        data       = 8'h3C;
        tx_en      = 1'b1;
        @(negedge clk);
        chk("b2b_cs0", 32'(cs), 32'(1'b0));
        data       = 8'hC3;
        slave_next = s2;
        dones      = 0;
        for (int i = 0; i < 40 * D && dones == 0; i++) begin
            @(negedge clk);
            if (done_rx) dones++;
        end
        chk("b2b_dout1", 32'(dout), 32'(s1));
        chk("b2b_cs_hi", 32'(cs), 32'(1'b1));
        @(negedge clk);
        chk("b2b_cs_lo", 32'(cs), 32'(1'b0));
        for (int i = 0; i < 40 * D && dones == 1; i++) begin
            @(negedge clk);
            if (done_rx) dones++;
        end
        tx_en = 1'b0;
        chk("b2b_dones", dones, 2);
        chk("b2b_dout2", 32'(dout), 32'(s2));
        repeat (2) @(negedge clk);

        for (int n = 0; n < 10; n++) begin
            xfer(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_full_duplex.md
SPI_FULL_DUPLEX -- requirements
Module: spi_full_duplex

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: number of clk cycles per sclk half-period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port data, input, 8 bits: transmit byte, sampled at transfer start.
REQ-005 SHALL have port tx_en, input, 1 bit: level request to start a transfer.
REQ-006 SHALL have port miso, input, 1 bit: serial data from the slave.
REQ-007 SHALL have port mosi, output, 1 bit: serial data to the slave, MSB first.
REQ-008 SHALL have port sclk, output, 1 bit: serial clock, idle low (CPOL=0).
REQ-009 SHALL have port cs, output, 1 bit: chip select, active-low.
REQ-010 SHALL have port dout, output, 8 bits: last fully received byte.
REQ-011 SHALL have port done_rx, output, 1 bit: one-clk pulse when dout is updated.

Function
REQ-012 SHALL implement an FSM with states IDLE, XFER and DONE.
REQ-013 In IDLE: cs=1, sclk=0, mosi=0, and the divider and bit counters held at 0.
REQ-014 IDLE->XFER SHALL occur on the first clk edge with tx_en=1; on that edge data is loaded into the TX shift register and cs goes to 0.
REQ-015 In XFER, sclk SHALL toggle every CLK_DIV clk cycles (sclk period 2*CLK_DIV); the first rising edge occurs CLK_DIV cycles after cs falls.
REQ-016 Mode 1 (CPHA=1): on each sclk rising edge, mosi SHALL be driven with the next TX bit, MSB (data[7]) first.
REQ-017 On each sclk falling edge, miso SHALL be shifted into the RX shift register LSB-in, so the first sampled bit ends up in bit 7.
REQ-018 After the 8th falling edge the FSM SHALL go to DONE with sclk=0; a transfer is exactly 8 sclk pulses.
REQ-019 In DONE, for one clk: dout <= RX register, done_rx=1, cs=1, mosi=0; then return to IDLE.
REQ-020 done_rx SHALL be high for exactly one clk per transfer; dout SHALL hold its value until the next DONE.
REQ-021 If tx_en is still 1 in IDLE, a new transfer SHALL start on that edge, giving back-to-back transfers separated by one IDLE cycle with cs high.
REQ-022 tx_en and data changes during XFER/DONE SHALL be ignored.
REQ-023 Total latency SHALL be 16*CLK_DIV+1 clk cycles from cs falling to the done_rx pulse.

Reset
REQ-024 While rst=0, asynchronously: state=IDLE, cs=1, sclk=0, mosi=0, dout=8'h00, done_rx=0, all shift registers and counters cleared.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done_rx pulse and no dout update.
REQ-026 After rst deasserts, the block SHALL wait in IDLE for tx_en.

Structure
REQ-027 State encoding and default CLK_DIV SHALL live in a shared package, spi_pkg.
REQ-028 An optional sub-module, spi_clk_gen, SHALL generate sclk plus one-clk rise/fall strobes from CLK_DIV; all other logic stays in spi_full_duplex.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset: hold rst=0 for 5 clk with tx_en=1 -> cs=1, sclk=0, mosi=0, dout=00, done_rx=0 throughout.
REQ-031 Basic transfer: data=8'hAA, tx_en=1, slave drives 01010101 MSB first (updating on sclk rise) -> mosi sequence 1,0,1,0,1,0,1,0 at the falling edges, 8 sclk pulses, then dout=8'h55 with a one-clk done_rx.
REQ-032 Timing: CLK_DIV=4 -> sclk period 8 clk, done_rx 65 clk after cs falls, cs high in the same cycle as done_rx.
REQ-033 Back-to-back: tx_en held high with data 8'h3C then 8'hC3 -> two transfers, cs high for exactly 1 clk between them, done_rx pulsed twice.
REQ-034 Abort: assert rst after 3 sclk pulses -> immediate idle outputs, no done_rx, dout unchanged at 00.
REQ-035 Stable inputs: toggle data and tx_en mid-transfer -> mosi bits still match the byte latched at start.
